// File: rtl/line_follow_controller.sv
// ============================================================================
// line_follow_controller : tracker debounce + drive FSM + per-wheel duty/dir
// Optional duty ramp: define TRACKER_RAMP_EN.          Revision: 1.0
// ============================================================================
`default_nettype none

module line_follow_controller #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SEARCH_CYCLES = 50000000,
  parameter logic [9:0]  SPEED_FAST    = 10'd800,
  parameter logic [9:0]  SPEED_SLOW    = 10'd300,
  parameter logic [9:0]  SPEED_SEARCH  = 10'd500
`ifdef TRACKER_RAMP_EN
  ,
  parameter logic [9:0]  RAMP_STEP     = 10'd50,
  parameter int unsigned RAMP_DIV      = 1000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] tracker_state,
  output logic [9:0] left_duty,
  output logic [9:0] right_duty,
  output logic       left_dir,
  output logic       right_dir,
  output logic [2:0] mode,
  output logic       lost
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FORWARD = 3'd1;
  localparam logic [2:0] S_STEER_L = 3'd2;
  localparam logic [2:0] S_STEER_R = 3'd3;
  localparam logic [2:0] S_SEARCH  = 3'd4;
  localparam logic [2:0] S_STOP    = 3'd5;

  localparam logic       SIDE_LEFT   = 1'b0;
  localparam logic       SIDE_RIGHT  = 1'b1;
  localparam logic [7:0] STABLE_C    = 8'(STABLE_CYCLES);
  localparam logic [31:0] SEARCH_LAST = 32'(SEARCH_CYCLES - 1);

  logic [1:0]  sample, prev_sample, filtered;
  logic [7:0]  stable_cnt, stable_cnt_nxt;
  logic [2:0]  state, state_nxt;
  logic        last_side, last_side_nxt;
  logic [31:0] search_cnt, search_cnt_nxt;
  logic        do_select;
  logic [9:0]  tgt_left, tgt_right;
  logic        tgt_left_dir, tgt_right_dir;

  // Run length of identical registered samples, saturating at 255.
  always_comb begin
    if (sample != prev_sample)
      stable_cnt_nxt = 8'd1;
    else if (stable_cnt == 8'hFF)
      stable_cnt_nxt = stable_cnt;
    else
      stable_cnt_nxt = stable_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample      <= 2'b10;
      prev_sample <= 2'b10;
      stable_cnt  <= 8'd0;
      filtered    <= 2'b10;
    end else begin
      sample      <= tracker_state;
      prev_sample <= sample;
      stable_cnt  <= stable_cnt_nxt;
      if (stable_cnt_nxt >= STABLE_C)
        filtered <= sample;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_side  <= SIDE_RIGHT;
      search_cnt <= 32'd0;
    end else begin
      state      <= state_nxt;
      last_side  <= last_side_nxt;
      search_cnt <= search_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_side_nxt  = last_side;
    search_cnt_nxt = search_cnt;
    do_select      = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:                         state_nxt = S_FORWARD;
        S_FORWARD, S_STEER_L, S_STEER_R: do_select = 1'b1;
        S_SEARCH: begin
          if (filtered == 2'b10 && last_side == SIDE_RIGHT)
            state_nxt = S_STEER_R;
          else if (filtered != 2'b00)
            do_select = 1'b1;
          else if (search_cnt == SEARCH_LAST)
            state_nxt = S_STOP;
          else
            search_cnt_nxt = search_cnt + 32'd1;
        end
        S_STOP:  state_nxt = S_STOP;
        default: state_nxt = S_IDLE;
      endcase
    end
    // Junction (11) keeps driving forward without touching last_side.
    if (do_select) begin
      case (filtered)
        2'b01: begin
          state_nxt     = S_STEER_L;
          last_side_nxt = SIDE_LEFT;
        end
        2'b10: begin
          state_nxt     = S_FORWARD;
          last_side_nxt = SIDE_RIGHT;
        end
        2'b11:   state_nxt = S_FORWARD;
        default: begin
          state_nxt      = S_SEARCH;
          search_cnt_nxt = 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    tgt_left      = 10'd0;
    tgt_right     = 10'd0;
    tgt_left_dir  = 1'b1;
    tgt_right_dir = 1'b1;
    case (state_nxt)
      S_FORWARD: begin
        tgt_left  = SPEED_FAST;
        tgt_right = SPEED_FAST;
      end
      S_STEER_L: begin
        tgt_left  = SPEED_SLOW;
        tgt_right = SPEED_FAST;
      end
      S_STEER_R: begin
        tgt_left  = SPEED_FAST;
        tgt_right = SPEED_SLOW;
      end
      S_SEARCH: begin
        tgt_left      = SPEED_SEARCH;
        tgt_right     = SPEED_SEARCH;
        tgt_left_dir  = (last_side_nxt == SIDE_RIGHT);
        tgt_right_dir = (last_side_nxt == SIDE_LEFT);
      end
      default: ;
    endcase
  end

`ifdef TRACKER_RAMP_EN
  localparam logic [31:0] RAMP_LAST = 32'(RAMP_DIV - 1);

  logic [31:0] ramp_cnt;
  logic        ramp_tick, ramp_hard;

  assign ramp_tick = (ramp_cnt == RAMP_LAST);
  assign ramp_hard = (state_nxt == S_IDLE) || (state_nxt == S_STOP);

  function automatic logic [9:0] ramp_duty(input logic [9:0] cur, input logic [9:0] tgt,
                                           input logic cur_dir, input logic tgt_dir,
                                           input logic hard, input logic tick);
    if (cur_dir != tgt_dir && !hard)
      return 10'd0;
    else if (hard || tgt <= cur)
      return tgt;
    else if (!tick)
      return cur;
    else if ((tgt - cur) > RAMP_STEP)
      return cur + RAMP_STEP;
    else
      return tgt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ramp_cnt <= 32'd0;
    else if (ramp_tick)
      ramp_cnt <= 32'd0;
    else
      ramp_cnt <= ramp_cnt + 32'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_duty  <= 10'd0;
      right_duty <= 10'd0;
      left_dir   <= 1'b1;
      right_dir  <= 1'b1;
      lost       <= 1'b0;
    end else begin
`ifdef TRACKER_RAMP_EN
      left_duty  <= ramp_duty(left_duty, tgt_left, left_dir, tgt_left_dir, ramp_hard, ramp_tick);
      right_duty <= ramp_duty(right_duty, tgt_right, right_dir, tgt_right_dir, ramp_hard, ramp_tick);
`else
      left_duty  <= tgt_left;
      right_duty <= tgt_right;
`endif
      left_dir   <= tgt_left_dir;
      right_dir  <= tgt_right_dir;
      lost       <= (state_nxt == S_STOP);
    end
  end

  assign mode = state;

endmodule

`default_nettype wire

// File: tb/tb_line_follow_controller.sv
// ============================================================================
// tb_line_follow_controller : directed + random stimulus against a cycle model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_line_follow_controller;

  localparam int STABLE = 4;
  localparam int SEARCH = 20;
  localparam int FAST   = 800;
  localparam int SLOW   = 300;
  localparam int SPIN   = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] tracker_state = 2'b10;
  logic [9:0] left_duty, right_duty;
  logic       left_dir, right_dir;
  logic [2:0] mode;
  logic       lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_follow_controller #(
    .STABLE_CYCLES(STABLE),
    .SEARCH_CYCLES(SEARCH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .tracker_state (tracker_state),
    .left_duty     (left_duty),
    .right_duty    (right_duty),
    .left_dir      (left_dir),
    .right_dir     (right_dir),
    .mode          (mode),
    .lost          (lost)
  );

  // Reference model: driving mode by name, elapsed search time, raw sample history.
  int         m_mode;
  bit         m_side_right;
  int         m_search_start;
  int         m_cyc;
  logic [1:0] m_samp;
  logic [1:0] m_filt;
  logic [1:0] seen[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode         = 0;
    m_side_right   = 1'b1;
    m_search_start = 0;
    m_cyc          = 0;
    m_samp         = 2'b10;
    m_filt         = 2'b10;
    seen.delete();
  endtask

  task automatic follow(input logic [1:0] f);
    if (f == 2'b01) begin
      m_mode = 2; m_side_right = 1'b0;
    end else if (f == 2'b10) begin
      m_mode = 1; m_side_right = 1'b1;
    end else if (f == 2'b11) begin
      m_mode = 1;
    end else begin
      m_mode = 4; m_search_start = m_cyc;
    end
  endtask

  task automatic model_edge(input logic en, input logic [1:0] trk);
    bit same;
    m_cyc++;
    if (!en) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode >= 1 && m_mode <= 3) follow(m_filt);
    else if (m_mode == 4) begin
      if (m_filt == 2'b10 && m_side_right) m_mode = 3;
      else if (m_filt != 2'b00) follow(m_filt);
      else if (m_cyc - m_search_start == SEARCH) m_mode = 5;
    end
    // Tracker code is accepted once the last STABLE registered samples agree.
    seen.push_back(m_samp);
    if (seen.size() > STABLE) void'(seen.pop_front());
    same = (seen.size() == STABLE);
    foreach (seen[i]) if (seen[i] != seen[0]) same = 1'b0;
    if (same) m_filt = seen[0];
    m_samp = trk;
  endtask

  task automatic compare_all(input string where);
    int el, er, dl, dr;
    el = 0; er = 0; dl = 1; dr = 1;
    case (m_mode)
      1: begin el = FAST; er = FAST; end
      2: begin el = SLOW; er = FAST; end
      3: begin el = FAST; er = SLOW; end
      4: begin el = SPIN; er = SPIN; dl = m_side_right ? 1 : 0; dr = m_side_right ? 0 : 1; end
      default: ;
    endcase
    check({where, ".mode"},       int'(mode),       m_mode);
    check({where, ".left_duty"},  int'(left_duty),  el);
    check({where, ".right_duty"}, int'(right_duty), er);
    check({where, ".left_dir"},   int'(left_dir),   dl);
    check({where, ".right_dir"},  int'(right_dir),  dr);
    check({where, ".lost"},       int'(lost),       (m_mode == 5) ? 1 : 0);
  endtask

  task automatic step(input string where, input logic en, input logic [1:0] trk);
    enable        = en;
    tracker_state = trk;
    @(posedge clk);
    model_edge(en, trk);
    @(negedge clk);
    compare_all(where);
  endtask

  task automatic hold(input string where, input logic en, input logic [1:0] trk, input int n);
    for (int k = 0; k < n; k++) step(where, en, trk);
  endtask

  initial begin
    logic [1:0] trk;
    logic       en;
    int         len;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all("in_reset");
    reset = 1'b1;
    hold("idle", 1'b0, 2'b10, 8);

    hold("fwd", 1'b1, 2'b10, 10);
    hold("glitch", 1'b1, 2'b01, 3);
    hold("glitch_back", 1'b1, 2'b10, 8);
    hold("steer_l", 1'b1, 2'b01, 8);
    hold("search_l", 1'b1, 2'b00, 30);
    hold("disable", 1'b0, 2'b00, 3);
    hold("fwd2", 1'b1, 2'b10, 10);
    hold("search_r", 1'b1, 2'b00, 12);
    hold("reacq_r", 1'b1, 2'b10, 10);
    hold("search_r2", 1'b1, 2'b00, 12);
    hold("junction", 1'b1, 2'b11, 10);
    hold("search_j", 1'b1, 2'b00, 10);
    hold("search_off", 1'b0, 2'b00, 2);

    // Asynchronous reset lands between edges and must clear outputs at once.
    hold("pre_rst", 1'b1, 2'b10, 8);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    hold("post_rst", 1'b1, 2'b10, 8);

    for (int seg = 0; seg < 400; seg++) begin
      trk = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 19) != 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      if (!en) len = $urandom_range(1, 3);
      hold("rand", en, trk, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_follow_controller.md
# line_follow_controller

Sequencing controller between the three-sensor tracker and the two motor PWM drivers of the line-following car. It debounces the 2-bit tracker state, runs a driving state machine (forward, steer, search, stop), and issues per-wheel direction and 10-bit duty commands. It adds lost-line recovery: a timed search spin toward the last seen side, then a safe stop.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a new tracker state (1..255).
- SEARCH_CYCLES, 50000000: maximum SEARCH duration in clocks before STOP (32-bit counter).
- SPEED_FAST, 10'd800: duty on both wheels in FORWARD.
- SPEED_SLOW, 10'd300: inner-wheel duty while steering.
- SPEED_SEARCH, 10'd500: duty of both wheels during the search spin.
- RAMP_STEP, 10'd50 / RAMP_DIV, 1000: ramp increment and period in clocks (used only with TRACKER_RAMP_EN).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 = drive, 0 = hold IDLE.
- tracker_state  input  2  00 no line, 01 line left, 10 line centre/right, 11 junction/wide.
- left_duty, right_duty  output  10  PWM duty command per wheel.
- left_dir, right_dir  output  1  1 = forward, 0 = reverse.
- mode  output  3  current FSM state encoding.
- lost  output  1  high in STOP after a failed search.

## Operation
- Reset values: duties 0, dirs 1, mode IDLE (3'd0), lost 0, filtered state 2'b10, last_side RIGHT, all counters 0.
- Input path: tracker_state registered once; stability counter increments while sample equals previous sample, reloads to 1 on change; filtered state loads sample when count reaches STABLE_CYCLES; counter saturates.
- States (mode): IDLE 0, FORWARD 1, STEER_L 2, STEER_R 3, SEARCH 4, STOP 5.
- IDLE: duties 0. enable=1 -> FORWARD.
- Driving states select by filtered state: 10 or 11 -> FORWARD; 01 -> STEER_L (last_side=LEFT); 00 -> SEARCH (search counter cleared).
- STEER_L: left_duty=SPEED_SLOW, right_duty=SPEED_FAST. STEER_R is not entered from tracker code 10; it is entered only from SEARCH when last_side=RIGHT and a line is reacquired as 10, for one decision cycle, then normal selection resumes. FORWARD sets last_side=RIGHT when filtered=10.
- SEARCH: spin in place toward last_side (LEFT: left_dir=0, right_dir=1; RIGHT: the mirror), both duties SPEED_SEARCH. Filtered state non-zero -> corresponding driving state. Counter reaches SEARCH_CYCLES-1 with filtered still 00 -> STOP.
- STOP: duties 0, lost=1; remains until enable falls (-> IDLE, lost cleared) or reset.
- enable=0 in any state -> IDLE on next edge, duties 0 that edge; takes priority over all transitions.
- Junction code 11 never triggers SEARCH and does not update last_side.

## Timing
- Filtered state updates on the edge where the STABLE_CYCLES-th consecutive identical registered sample is seen; FSM state and all outputs are registered and update one edge later. Total: an input change held steadily appears on outputs STABLE_CYCLES+2 edges after the first edge that samples it.
- Glitches shorter than STABLE_CYCLES samples never reach the FSM.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), no ramp.
- SEARCH counter is 32-bit and does not wrap; it is cleared on every SEARCH entry.

## Configuration
- TRACKER_RAMP_EN defined: each duty output moves toward its target by RAMP_STEP once every RAMP_DIV clocks when the target is higher (clamped at target); decreases, direction reversals, IDLE, and STOP apply the target immediately. Direction change forces duty to 0 first, then ramps.
- TRACKER_RAMP_EN undefined: duties equal the state target on the same edge the state is entered; ramp counters are not built.

## Test plan
- Reset low, then release with enable=0 -> duties 0, dirs 1, mode 0, lost 0 indefinitely.
- enable=1, tracker_state=10, STABLE_CYCLES=4 -> mode 1, both duties 800 on the edge after entry; no ramp build.
- From FORWARD, drive 01 for 3 cycles then back to 10 -> mode stays 1; hold 01 for 4 -> at the 6th edge mode 2, left_duty 300, right_duty 800.
- After STEER_L, drive 00 with SEARCH_CYCLES=20 -> mode 4, left_dir 0, right_dir 1, duties 500; after 20 cycles mode 5, lost 1, duties 0; enable low -> mode 0, lost 0.
- In SEARCH, drive 11 stable -> mode 1 and last_side unchanged; drive enable low during SEARCH -> mode 0 next edge.
- With TRACKER_RAMP_EN, RAMP_STEP=50, RAMP_DIV=10 -> IDLE to FORWARD duty rises 0,50,...,800 every 10 clocks; reset mid-ramp -> duty 0 immediately.
